if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline; sits directly upstream of the decode stage.
- Generates the next PC and drives the synchronous instruction SRAM.
- Holds the fetched instruction in the IF->ID pipeline slot under a valid/allowin handshake.
- Redirects on branches resolved in decode and cancels the wrong-path instruction (no delay slot).

Parameters:
RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
clk  input  1  single system clock, all state on rising edge
resetn  input  1  synchronous active-low reset
id_allowin  input  1  decode stage can accept an instruction this cycle
id_br_taken  input  1  redirect request from decode, qualified by the decode instruction firing
id_br_target  input  32  redirect PC, word aligned
inst_sram_en  output  1  SRAM read request this cycle
inst_sram_we  output  4  byte write enables, constant 4'h0
inst_sram_addr  output  32  fetch address (nextpc)
inst_sram_wdata  output  32  constant 32'h0
inst_sram_rdata  input  32  read data, valid exactly one cycle after the request, undefined afterwards
if_to_id_valid  output  1  IF slot holds a valid, non-cancelled instruction
if_inst  output  32  instruction in IF slot
if_pc  output  32  PC of instruction in IF slot

Behaviour:
- Registers:
  - fs_valid
  - fs_pc
  - rdata_live: SRAM issued a read last cycle into the current slot
  - buf_valid, buf_inst: stall capture
  - br_pending, br_target_r: deferred redirect
- Reset (resetn=0 at a clock edge):
  - Register values: fs_valid=0, fs_pc=RESET_PC-4, rdata_live=0, buf_valid=0, br_pending=0, buf_inst=0, br_target_r=0.
  - Outputs while resetn=0: if_to_id_valid=0, inst_sram_en=0.
  - Reset mid-operation discards all pending state.
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = !fs_valid | id_allowin.
  - if_to_id_valid = fs_valid & !id_br_taken & !br_pending. A taken branch kills the instruction sitting in IF.
- Next PC, priority order:
  - id_br_taken → id_br_target.
  - br_pending → br_target_r.
  - otherwise fs_pc+4 (32-bit wrap, no overflow flag).
- Fetch issue:
  - inst_sram_en = resetn & fs_allowin; inst_sram_addr = nextpc.
  - On a cycle with inst_sram_en=1: fs_valid<=1, fs_pc<=nextpc, rdata_live<=1, buf_valid<=0, br_pending<=0.
  - The new instruction appears in IF one cycle after its request (1-cycle fetch latency). The first fetch after reset release is RESET_PC.
- Stall capture:
  - When fs_valid & rdata_live & !fs_allowin: buf_inst<=inst_sram_rdata, buf_valid<=1, rdata_live<=0.
  - if_inst = buf_valid ? buf_inst : inst_sram_rdata.
  - A stall of any length returns the correct instruction.
- Deferred redirect:
  - If id_br_taken while fs_allowin=0 (protocol does not normally produce this; must still be handled): br_pending<=1, br_target_r<=id_br_target, fs_valid<=0, buf_valid<=0.
  - Clearing fs_valid raises fs_allowin next cycle, which issues the fetch of br_target_r.
- Simultaneous id_br_taken and id_allowin:
  - The current IF instruction is not passed to decode.
  - The target is fetched in the same cycle and occupies IF next cycle.
- Back-to-back redirects: the later id_br_taken overrides any pending target.
- Alignment: nextpc[1:0] is not checked here; the address exception belongs to a later block.

Decomposition:
- Shared package (cpu_defs), reused by decode/execute:
  - RESET_PC constant.
  - Pipeline bus width constant for the IF->ID bus {if_pc, if_inst} = 64.
- No sub-module. The stall buffer is two registers and does not justify one.

Test Plan:
- Reset release, id_allowin=1 constant:
  - Addresses: inst_sram_addr sequence 0x1c000000, 0x1c000004, 0x1c000008.
  - IF output: if_pc follows one cycle later with if_to_id_valid=1 from the second cycle.
- Stall with id_allowin=0 for 3 cycles while holding PC 0x1c000008, SRAM data 0x02800421 then garbage:
  - inst_sram_en=0 during the stall.
  - if_inst stays 0x02800421; if_pc stays 0x1c000008.
  - Resume fetches 0x1c00000c.
- id_br_taken=1, id_br_target=0x1c000100 with IF holding 0x1c000010:
  - that cycle: if_to_id_valid=0, inst_sram_addr=0x1c000100.
  - next cycle: if_pc=0x1c000100.
- id_br_taken with id_allowin=0, target 0x1c000200:
  - br_pending set and IF instruction dropped.
  - Next cycle fetch 0x1c000200; no instruction from the old path reaches decode.
- resetn pulsed low for one cycle during a 2-cycle stall with buf_valid=1:
  - if_to_id_valid=0 during reset.
  - First fetch after release is 0x1c000000; buffer contents never appear.
- PC wrap: force fs_pc to 0xfffffffc via redirect → next sequential fetch address 0x00000000.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions for the 5-stage LoongArch core (IF/ID/EX reuse these).
package cpu_defs;

    localparam logic [31:0] CPU_RESET_PC  = 32'h1c000000;
    localparam int unsigned IF_ID_BUS_W   = 64;  // {if_pc, if_inst}

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, synchronous inst SRAM request,
// IF->ID slot with stall capture of SRAM data and deferred branch redirect.
module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allowin,
    input  logic        id_br_taken,
    input  logic [31:0] id_br_target,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_to_id_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_rdata_live;
    logic        r_buf_valid;
    logic [31:0] r_buf_inst;
    logic        r_br_pending;
    logic [31:0] r_br_target;

    logic        w_fs_allowin;
    logic        w_fetch;
    logic [31:0] w_nextpc;

    always_comb begin
        w_fs_allowin = !r_fs_valid || id_allowin;
        w_fetch      = resetn && w_fs_allowin;
        if (id_br_taken)
            w_nextpc = id_br_target;
        else if (r_br_pending)
            w_nextpc = r_br_target;
        else
            w_nextpc = r_fs_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fs_valid   <= 1'b0;
            r_fs_pc      <= RESET_PC - 32'd4;
            r_rdata_live <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_inst   <= '0;
            r_br_pending <= 1'b0;
            r_br_target  <= '0;
        end else if (w_fetch) begin
            r_fs_valid   <= 1'b1;
            r_fs_pc      <= w_nextpc;
            r_rdata_live <= 1'b1;
            r_buf_valid  <= 1'b0;
            r_br_pending <= 1'b0;
        end else if (id_br_taken) begin
            // Redirect while IF cannot accept: drop the slot; the freed slot fetches the target next cycle.
            r_br_pending <= 1'b1;
            r_br_target  <= id_br_target;
            r_fs_valid   <= 1'b0;
            r_buf_valid  <= 1'b0;
        end else if (r_fs_valid && r_rdata_live) begin
            // SRAM data is only valid one cycle after the request; hold it for the rest of the stall.
            r_buf_inst   <= inst_sram_rdata;
            r_buf_valid  <= 1'b1;
            r_rdata_live <= 1'b0;
        end
    end

    assign inst_sram_en    = w_fetch;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = '0;

    assign if_to_id_valid = resetn && r_fs_valid && !id_br_taken && !r_br_pending;
    assign if_inst        = r_buf_valid ? r_buf_inst : inst_sram_rdata;
    assign if_pc          = r_fs_pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a one-cycle-latency instruction SRAM model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allowin;
    logic        id_br_taken;
    logic [31:0] id_br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        if_to_id_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    int total = 0;
    int bad   = 0;
    logic [31:0] garbage = 32'hbad00000;

    if_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .id_allowin      (id_allowin),
        .id_br_taken     (id_br_taken),
        .id_br_target    (id_br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .if_to_id_valid  (if_to_id_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h1c000008) return 32'h02800421;
        return a ^ 32'ha5a50000;
    endfunction

    // Data valid exactly one cycle after a request; otherwise returns changing junk.
    always @(posedge clk) begin
        garbage <= garbage + 32'd1;
        if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
        else              inst_sram_rdata <= garbage;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; id_allowin = 1'b1; id_br_taken = 1'b0; id_br_target = '0;
        tick(); tick();
        chk("rst_valid", 32'(if_to_id_valid), 32'd0);
        chk("rst_en", 32'(inst_sram_en), 32'd0);
        chk("rst_pc", if_pc, 32'h1bfffffc);
        chk("we", 32'(inst_sram_we), 32'd0);
        chk("wdata", inst_sram_wdata, 32'd0);

        // sequential fetch
        resetn = 1'b1; #1;
        chk("seq0_en", 32'(inst_sram_en), 32'd1);
        chk("seq0_addr", inst_sram_addr, 32'h1c000000);
        chk("seq0_valid", 32'(if_to_id_valid), 32'd0);
        tick();
        chk("seq1_pc", if_pc, 32'h1c000000);
        chk("seq1_valid", 32'(if_to_id_valid), 32'd1);
        chk("seq1_inst", if_inst, 32'hb9a50000);
        chk("seq1_addr", inst_sram_addr, 32'h1c000004);
        tick();
        chk("seq2_pc", if_pc, 32'h1c000004);
        chk("seq2_addr", inst_sram_addr, 32'h1c000008);
        tick();
        chk("seq3_pc", if_pc, 32'h1c000008);
        chk("seq3_inst", if_inst, 32'h02800421);

        // 3-cycle stall
        id_allowin = 1'b0; #1;
        chk("stall_en", 32'(inst_sram_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_inst", if_inst, 32'h02800421);
            chk("stall_pc", if_pc, 32'h1c000008);
            chk("stall_en", 32'(inst_sram_en), 32'd0);
        end
        id_allowin = 1'b1; #1;
        chk("resume_addr", inst_sram_addr, 32'h1c00000c);
        chk("resume_inst", if_inst, 32'h02800421);
        tick();
        chk("resume_pc", if_pc, 32'h1c00000c);
        chk("resume_inst2", if_inst, 32'hb9a5000c);
        tick();
        chk("pre_br_pc", if_pc, 32'h1c000010);

        // branch with allowin
        id_br_taken = 1'b1; id_br_target = 32'h1c000100; #1;
        chk("br_valid", 32'(if_to_id_valid), 32'd0);
        chk("br_addr", inst_sram_addr, 32'h1c000100);
        tick();
        id_br_taken = 1'b0; #1;
        chk("br_pc", if_pc, 32'h1c000100);
        chk("br_inst", if_inst, 32'hb9a50100);
        chk("br_valid2", 32'(if_to_id_valid), 32'd1);

        // deferred redirect
        id_allowin = 1'b0; id_br_taken = 1'b1; id_br_target = 32'h1c000200; #1;
        chk("dbr_valid", 32'(if_to_id_valid), 32'd0);
        chk("dbr_en", 32'(inst_sram_en), 32'd0);
        tick();
        id_br_taken = 1'b0; #1;
        chk("dbr_pend_valid", 32'(if_to_id_valid), 32'd0);
        chk("dbr_en2", 32'(inst_sram_en), 32'd1);
        chk("dbr_addr", inst_sram_addr, 32'h1c000200);
        tick();
        chk("dbr_pc", if_pc, 32'h1c000200);
        chk("dbr_valid2", 32'(if_to_id_valid), 32'd1);
        chk("dbr_inst", if_inst, 32'hb9a50200);

        // back-to-back: later redirect overrides pending target
        id_br_taken = 1'b1; id_br_target = 32'h1c000300; tick();
        id_br_target = 32'h1c000400; #1;
        chk("b2b_addr", inst_sram_addr, 32'h1c000400);
        tick();
        id_br_taken = 1'b0; id_allowin = 1'b1; #1;
        chk("b2b_pc", if_pc, 32'h1c000400);

        // reset during a stall with buffer loaded
        id_allowin = 1'b0; tick(); tick();
        chk("rbuf_inst", if_inst, 32'hb9a50400);
        resetn = 1'b0; #1;
        chk("rbuf_valid", 32'(if_to_id_valid), 32'd0);
        chk("rbuf_en", 32'(inst_sram_en), 32'd0);
        tick();
        resetn = 1'b1; #1;
        chk("rrel_addr", inst_sram_addr, 32'h1c000000);
        chk("rrel_valid", 32'(if_to_id_valid), 32'd0);
        tick();
        chk("rrel_pc", if_pc, 32'h1c000000);
        chk("rrel_inst", if_inst, 32'hb9a50000);
        id_allowin = 1'b1;

        // PC wrap
        id_br_taken = 1'b1; id_br_target = 32'hfffffffc; tick();
        id_br_taken = 1'b0; #1;
        chk("wrap_pc", if_pc, 32'hfffffffc);
        chk("wrap_addr", inst_sram_addr, 32'h00000000);
        tick();
        chk("wrap_pc2", if_pc, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
